// File: rtl/caliptra_prim_dom_and_ctrl_pkg.sv
// Shared types for the DOM AND controller: FSM state encoding.
package caliptra_prim_dom_and_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RND  = 3'd1,
    ST_MUL  = 3'd2,
    ST_CAP  = 3'd3,
    ST_OUT  = 3'd4
  } dom_state_e;

endpackage

// File: rtl/caliptra_prim_dom_and_ctrl_if.sv
// Operand / randomness / result bundle of the DOM AND controller.
interface caliptra_prim_dom_and_ctrl_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a0;
  logic [DW-1:0] a1;
  logic [DW-1:0] b0;
  logic [DW-1:0] b1;
  logic          rnd_req;
  logic          rnd_ack;
  logic [DW-1:0] rnd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] q0;
  logic [DW-1:0] q1;
  logic [DW-1:0] prd;
  logic          busy;

  modport master (
    output in_valid, a0, a1, b0, b1, rnd_ack, rnd, out_ready,
    input  in_ready, rnd_req, out_valid, q0, q1, prd, busy
  );

  modport slave (
    input  in_valid, a0, a1, b0, b1, rnd_ack, rnd, out_ready,
    output in_ready, rnd_req, out_valid, q0, q1, prd, busy
  );
endinterface

// File: rtl/caliptra_prim_dom_and_2share.sv
// Two-share domain-oriented masked AND; cross-domain terms are re-masked with z.
module caliptra_prim_dom_and_2share #(
  parameter int DW       = 2,
  parameter int Pipeline = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  input  logic          z_valid_i,
  input  logic [DW-1:0] z_i,
  output logic [DW-1:0] q0_o,
  output logic [DW-1:0] q1_o,
  output logic [DW-1:0] prd_o
);
  logic [DW-1:0] t0_d, t1_d, t0_q, t1_q;

  assign t0_d = (a0_i & b1_i) ^ z_i;
  assign t1_d = (a1_i & b0_i) ^ z_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t0_q <= '0;
      t1_q <= '0;
    end else if (z_valid_i) begin
      t0_q <= t0_d;
      t1_q <= t1_d;
    end
  end

  if (Pipeline == 0) begin : gen_no_pipeline
    // Inner-domain terms stay combinational: operands must be held one more cycle.
    assign q0_o = (a0_i & b0_i) ^ t0_q;
    assign q1_o = (a1_i & b1_i) ^ t1_q;
  end else begin : gen_pipeline
    logic [DW-1:0] i0_q, i1_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        i0_q <= '0;
        i1_q <= '0;
      end else if (z_valid_i) begin
        i0_q <= a0_i & b0_i;
        i1_q <= a1_i & b1_i;
      end
    end
    assign q0_o = i0_q ^ t0_q;
    assign q1_o = i1_q ^ t1_q;
  end

  assign prd_o = t0_q;
endmodule

// File: rtl/caliptra_prim_dom_and_ctrl.sv
// Handshaking controller around one DOM AND: fetch shares, fetch randomness,
// multiply, capture the result shares and hold them until consumed.
module caliptra_prim_dom_and_ctrl
  import caliptra_prim_dom_and_ctrl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] a0_i,
  input  logic [DW-1:0] a1_i,
  input  logic [DW-1:0] b0_i,
  input  logic [DW-1:0] b1_i,
  output logic          rnd_req_o,
  input  logic          rnd_ack_i,
  input  logic [DW-1:0] rnd_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] q0_o,
  output logic [DW-1:0] q1_o,
  output logic [DW-1:0] prd_o,
  output logic          busy_o
);
  dom_state_e    state_q;
  logic [DW-1:0] a0_q, a1_q, b0_q, b1_q, z_q;
  logic [DW-1:0] q0_q, q1_q;
  logic          in_ready_q, rnd_req_q, z_valid_q, out_valid_q, busy_q;
  logic [DW-1:0] mul_q0, mul_q1;

  caliptra_prim_dom_and_2share #(
    .DW       (DW),
    .Pipeline (0)
  ) u_dom_and (
    .clk_i     (clk_i),
    .rst_ni    (~rst_i),
    .a0_i      (a0_q),
    .a1_i      (a1_q),
    .b0_i      (b0_q),
    .b1_i      (b1_q),
    .z_valid_i (z_valid_q),
    .z_i       (z_q),
    .q0_o      (mul_q0),
    .q1_o      (mul_q1),
    .prd_o     (prd_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      a0_q        <= '0;
      a1_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      z_q         <= '0;
      q0_q        <= '0;
      q1_q        <= '0;
      in_ready_q  <= 1'b1;
      rnd_req_q   <= 1'b0;
      z_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (in_valid_i && in_ready_q) begin
          a0_q       <= a0_i;
          a1_q       <= a1_i;
          b0_q       <= b0_i;
          b1_q       <= b1_i;
          state_q    <= ST_RND;
          in_ready_q <= 1'b0;
          rnd_req_q  <= 1'b1;
          busy_q     <= 1'b1;
        end
        ST_RND: if (rnd_ack_i) begin
          z_q       <= rnd_i;
          state_q   <= ST_MUL;
          rnd_req_q <= 1'b0;
          z_valid_q <= 1'b1;
        end
        ST_MUL: begin
          state_q   <= ST_CAP;
          z_valid_q <= 1'b0;
        end
        ST_CAP: begin
          // Operands are still valid here; scrub them as the result is taken.
          q0_q        <= mul_q0;
          q1_q        <= mul_q1;
          a0_q        <= '0;
          a1_q        <= '0;
          b0_q        <= '0;
          b1_q        <= '0;
          z_q         <= '0;
          state_q     <= ST_OUT;
          out_valid_q <= 1'b1;
        end
        ST_OUT: if (out_ready_i) begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          rnd_req_q   <= 1'b0;
          z_valid_q   <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign rnd_req_o   = rnd_req_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign q0_o        = q0_q;
  assign q1_o        = q1_q;
endmodule

// File: tb/tb_caliptra_prim_dom_and_ctrl.sv
// Self-checking bench: directed vector table, reset/spurious-ack sequences and
// randomized operations against an unmasked AND / latency model.
module tb_caliptra_prim_dom_and_ctrl;
  localparam int DW = 8;

  typedef struct {
    logic [DW-1:0] a0, a1, b0, b1, rnd;
    int            ack_dly;
    int            stall;
    logic [DW-1:0] exp_and;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  caliptra_prim_dom_and_ctrl_if #(.DW(DW)) bus();

  caliptra_prim_dom_and_ctrl #(.DW(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .a0_i        (bus.a0),
    .a1_i        (bus.a1),
    .b0_i        (bus.b0),
    .b1_i        (bus.b1),
    .rnd_req_o   (bus.rnd_req),
    .rnd_ack_i   (bus.rnd_ack),
    .rnd_i       (bus.rnd),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .q0_o        (bus.q0),
    .q1_o        (bus.q1),
    .prd_o       (bus.prd),
    .busy_o      (bus.busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 0);
    check({tag, " rnd_req"}, 32'(bus.rnd_req), 0);
    check({tag, " out_valid"}, 32'(bus.out_valid), 0);
    check({tag, " q0"}, 32'(bus.q0), 0);
    check({tag, " q1"}, 32'(bus.q1), 0);
    check({tag, " prd"}, 32'(bus.prd), 0);
  endtask

  // One full operation; expected latency: out_valid in cycle ack_dly+4 where
  // cycle 0 is the cycle in which the operands are offered and accepted.
  task automatic run_op(input string tag, input vec_t v);
    int out_cyc, req_cnt, cyc, guard;
    logic [DW-1:0] hq0, hq1;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, " in_ready before accept"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.a0 = v.a0; bus.a1 = v.a1; bus.b0 = v.b0; bus.b1 = v.b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a0 = DW'($urandom); bus.a1 = DW'($urandom);
    bus.b0 = DW'($urandom); bus.b1 = DW'($urandom);
    cyc = 1; out_cyc = -1; req_cnt = 0;
    while (out_cyc < 0 && cyc < 40) begin
      if (bus.out_valid) begin
        out_cyc = cyc;
      end else begin
        if (bus.rnd_req) req_cnt++;
        bus.rnd_ack = (cyc == v.ack_dly + 1);
        bus.rnd = bus.rnd_ack ? v.rnd : DW'($urandom);
        tick();
        bus.rnd_ack = 1'b0;
        cyc++;
      end
    end
    check({tag, " out_valid latency"}, 32'(out_cyc), 32'(v.ack_dly + 4));
    check({tag, " rnd_req cycles"}, 32'(req_cnt), 32'(v.ack_dly + 1));
    check({tag, " q0^q1"}, 32'(bus.q0 ^ bus.q1), 32'(v.exp_and));
    check({tag, " operand regs in OUT"},
          32'(dut.a0_q | dut.a1_q | dut.b0_q | dut.b1_q | dut.z_q), 0);
    hq0 = bus.q0;
    hq1 = bus.q1;
    for (int s = 0; s < v.stall; s++) begin
      bus.rnd_ack = 1'b1;
      bus.rnd = DW'($urandom) | DW'(1);
      tick();
      bus.rnd_ack = 1'b0;
      check({tag, " stall q0"}, 32'(bus.q0), 32'(hq0));
      check({tag, " stall q1"}, 32'(bus.q1), 32'(hq1));
      check({tag, " stall out_valid"}, 32'(bus.out_valid), 1);
      check({tag, " stall in_ready"}, 32'(bus.in_ready), 0);
      check({tag, " stall z_q after ack"}, 32'(dut.z_q), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 32'(bus.out_valid), 0);
    check({tag, " in_ready after handshake"}, 32'(bus.in_ready), 1);
    $display("op %s a=%02h^%02h b=%02h^%02h q=%02h^%02h lat=%0d", tag,
             v.a0, v.a1, v.b0, v.b1, hq0, hq1, out_cyc);
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    bus.in_valid = 1'b0; bus.rnd_ack = 1'b0; bus.out_ready = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0; bus.rnd = '0;

    vecs[0] = '{8'h5A, 8'hAA, 8'h11, 8'h2D, 8'h77, 0, 0, 8'h30};
    vecs[1] = '{8'h5A, 8'hAA, 8'h11, 8'h2D, 8'h77, 5, 0, 8'h30};
    vecs[2] = '{8'h5A, 8'hAA, 8'h11, 8'h2D, 8'h77, 0, 3, 8'h30};
    vecs[3] = '{8'hFF, 8'h00, 8'h0F, 8'hF0, 8'h00, 1, 0, 8'hFF};
    vecs[4] = '{8'hC3, 8'hC3, 8'hFF, 8'h00, 8'hA5, 0, 1, 8'h00};
    vecs[5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h3C, 2, 1, 8'h26};

    #1 rst = 1'b1;
    #1 check_idle_outputs("in reset");
    tick(); tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("after reset");
    check("after reset in_ready", 32'(bus.in_ready), 1);

    for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Spurious ack and out_ready while idle: nothing may move.
    bus.rnd_ack = 1'b1; bus.rnd = 8'hFF; bus.out_ready = 1'b1;
    tick();
    bus.rnd_ack = 1'b0; bus.out_ready = 1'b0;
    check("idle ack busy", 32'(bus.busy), 0);
    check("idle ack in_ready", 32'(bus.in_ready), 1);
    check("idle ack z_q", 32'(dut.z_q), 0);

    // Reset while the multiplier step is in progress.
    bus.in_valid = 1'b1;
    bus.a0 = 8'h5A; bus.a1 = 8'hAA; bus.b0 = 8'h11; bus.b1 = 8'h2D;
    tick();
    bus.in_valid = 1'b0;
    bus.rnd_ack = 1'b1; bus.rnd = 8'h77;
    tick();
    bus.rnd_ack = 1'b0;
    check("mul busy before reset", 32'(bus.busy), 1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset in MUL");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no output after abandoned op", 32'(bus.out_valid), 0);
    end
    check("in_ready after abandon", 32'(bus.in_ready), 1);
    run_op("post-reset", vecs[5]);

    for (int n = 0; n < 100; n++) begin
      rv.a0 = DW'($urandom); rv.a1 = DW'($urandom);
      rv.b0 = DW'($urandom); rv.b1 = DW'($urandom);
      rv.rnd = DW'($urandom);
      rv.ack_dly = int'($urandom_range(0, 3));
      rv.stall = int'($urandom_range(0, 2));
      rv.exp_and = (rv.a0 ^ rv.a1) & (rv.b0 ^ rv.b1);
      run_op($sformatf("rand%0d", n), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/caliptra_prim_dom_and_ctrl.md
CALIPTRA_PRIM_DOM_AND_CTRL -- requirements
Module: caliptra_prim_dom_and_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, meaning share/operand width in bits.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_i, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port in_valid_i, input, 1, masked operand request.
REQ-005 SHALL have port in_ready_o, output, 1, operand acceptance.
REQ-006 SHALL have ports a0_i, a1_i, b0_i, b1_i, each input, DW, the operand shares.
REQ-007 SHALL have port rnd_req_o, output, 1, fresh randomness request.
REQ-008 SHALL have port rnd_ack_i, input, 1, randomness delivered this cycle.
REQ-009 SHALL have port rnd_i, input, DW, randomness, valid with rnd_ack_i.
REQ-010 SHALL have port out_valid_o, output, 1, result available.
REQ-011 SHALL have port out_ready_i, input, 1, result consumed.
REQ-012 SHALL have ports q0_o and q1_o, each output, DW, result shares.
REQ-013 SHALL have port prd_o, output, DW, pseudo-random data from the multiplier for downstream instances.
REQ-014 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RND, MUL, CAP and OUT.
REQ-016 SHALL drive in_ready_o high only in IDLE.
REQ-017 SHALL, on in_valid_i&&in_ready_o, register all four shares and go to RND.
REQ-018 SHALL, in RND, hold rnd_req_o high until rnd_ack_i.
REQ-019 SHALL, on rnd_ack_i in RND, register rnd_i into z_q and go to MUL in the same edge.
REQ-020 SHALL ignore rnd_ack_i outside RND: no state change and no z_q update.
REQ-021 SHALL, in MUL, drive the multiplier z_valid high for exactly one cycle, then go to CAP.
REQ-022 SHALL hold the multiplier operands (registered shares) stable from MUL through CAP (two cycles), satisfying the multiplier's two-cycle stability rule.
REQ-023 SHALL, in CAP, register the multiplier q0/q1 into the output registers, clear the operand registers and z_q to zero, then go to OUT.
REQ-024 SHALL, in OUT, hold out_valid_o high with q0_o/q1_o stable until out_ready_i.
REQ-025 SHALL, on out_valid_o&&out_ready_i, go to IDLE; in_ready_o rises the following cycle (no same-cycle bypass).
REQ-026 SHALL keep out_ready_i without effect outside OUT.
REQ-027 SHALL, with rnd_ack_i in the first RND cycle, make out_valid_o rise 4 cycles after the accept edge.
REQ-028 SHALL guarantee q0_o^q1_o == (a0^a1)&(b0^b1) of the accepted operands.
REQ-029 SHALL never combine shares of the same operand (a0 with a1, or b0 with b1) in any logic outside the multiplier.
REQ-030 SHALL drive prd_o directly from the multiplier prd output.

Reset
REQ-031 SHALL, on rst_i, force IDLE and zero all share, z_q and output registers asynchronously.
REQ-032 SHALL hold rnd_req_o=0, out_valid_o=0, busy_o=0 and q0_o=q1_o=prd_o=0 during and immediately after reset.
REQ-033 SHALL abandon any operation on reset mid-operation, with no output produced for it after release.

Structure
REQ-034 SHALL define the state enum typedef and its encoding in caliptra_prim_dom_and_ctrl_pkg.
REQ-035 SHALL instantiate one caliptra_prim_dom_and_2share with Pipeline=0, clocked by clk_i with its active-low reset driven by ~rst_i.

Verification
REQ-036 SHALL cover the basic case: DW=8, a0=0x5A, a1=0xAA, b0=0x11, b1=0x2D, rnd_ack_i immediate with rnd_i=0x77 -> out_valid_o at accept+4, q0_o^q1_o=0x30.
REQ-037 SHALL cover delayed randomness: rnd_ack_i delayed 5 cycles -> rnd_req_o high 6 cycles, state stays RND, out_valid_o at accept+9, result still 0x30.
REQ-038 SHALL cover backpressure: out_ready_i low 3 cycles in OUT -> q0_o/q1_o stable, in_ready_o low; in_ready_o high the cycle after the handshake.
REQ-039 SHALL cover a spurious ack: rnd_ack_i pulses in IDLE and in OUT -> no state change, z_q unchanged.
REQ-040 SHALL cover reset in MUL: rst_i asserted in MUL -> IDLE, all outputs 0; the next operand pair produces the correct AND.
REQ-041 SHALL cover back-to-back operations: 100 random operand/rnd pairs -> every result matches the unmasked AND; operand registers read zero in OUT.
